// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one fixed-latency pipelined adder among NREQ clients,
// with a tag pipeline that steers each result back to the requester that issued it.
module adder_rr_arbiter #(
    parameter  int NREQ = 4,
    parameter  int W    = 4,
    parameter  int LAT  = 9,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(LAT + 1)
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              issue_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_f,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic [CW-1:0]     inflight,
    output logic              busy
);
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          gid;
    logic                    found;
    logic                    gnt;
    int                      idx;
    logic [LAT-1:0]          tv;
    logic [LAT-1:0][IDW-1:0] tid;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = IDW'(idx);
            end
        end
    end

    assign gnt       = p_reset & issue_en & found;
    assign req_ready = gnt ? (NREQ'(1) << gid) : '0;
    assign add_a     = gnt ? req_a[gid*W +: W] : '0;
    assign add_b     = gnt ? req_b[gid*W +: W] : '0;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            ptr      <= IDW'(NREQ - 1);
            tv       <= '0;
            tid      <= '0;
            inflight <= '0;
        end else begin
            if (gnt) ptr <= gid;
            tv[0]    <= gnt;
            tid[0]   <= gid;
            for (int k = 1; k < LAT; k++) begin
                tv[k]  <= tv[k-1];
                tid[k] <= tid[k-1];
            end
            inflight <= inflight + CW'(gnt) - CW'(tv[LAT-1]);
        end
    end

    assign busy      = inflight != '0;
    assign rsp_valid = tv[LAT-1] ? (NREQ'(1) << tid[LAT-1]) : '0;
    assign rsp_id    = tv[LAT-1] ? tid[LAT-1] : '0;
    assign rsp_data  = tv[LAT-1] ? add_f : '0;
endmodule
